// File: rtl/ps2_key_rx.sv
// ps2_key_rx
//   PS/2 keyboard receiver. Synchronises the open-collector ps2_clk/ps2_data
//   lines, deframes 11-bit device-to-host frames (start, 8 data LSB-first,
//   odd parity, stop), strips break (F0) and extended (E0) prefixes and
//   delivers each make code with a PULSE_CYCLES-long key_int pulse.
//
//   Optional feature: define PS2_ASCII_EN to translate delivered make codes
//   to uppercase ASCII (unmapped codes become '?', extended codes dropped).
//
// Ports
//   clk        system clock (50 MHz)
//   rst_n      synchronous active-low reset
//   ps2_clk    raw PS/2 clock, asynchronous
//   ps2_data   raw PS/2 data, asynchronous
//   key_data   last delivered byte, held until the next delivery
//   key_int    high for PULSE_CYCLES cycles on each delivery
//   key_ext    delivered byte was preceded by E0
//   parity_err one-cycle pulse on a rejected frame
module ps2_key_rx #(
  parameter int PULSE_CYCLES   = 4,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] key_data,
  output logic       key_int,
  output logic       key_ext,
  output logic       parity_err
);

  typedef enum logic [1:0] {IDLE, RECV, CHECK} state_t;

  localparam logic [15:0] TO_LAST  = 16'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0]  PULSE_LD = 4'(PULSE_CYCLES);

  state_t      state, state_nx;
  logic        clk_m, clk_s, clk_d;
  logic        data_m, data_s;
  logic        fall;
  logic [3:0]  bit_cnt;
  logic [10:0] frame;
  logic [15:0] to_cnt;
  logic        timeout;
  logic        brk_flag, ext_flag;
  logic [3:0]  pulse_cnt;
  logic [7:0]  rx_byte;
  logic        frame_ok;
  logic        deliver;
  logic [7:0]  key_val;

`ifdef PS2_ASCII_EN
  function automatic logic [7:0] to_ascii(input logic [7:0] code);
    logic [7:0] a;
    case (code)
      8'h1C: a = "A"; 8'h32: a = "B"; 8'h21: a = "C"; 8'h23: a = "D";
      8'h24: a = "E"; 8'h2B: a = "F"; 8'h34: a = "G"; 8'h33: a = "H";
      8'h43: a = "I"; 8'h3B: a = "J"; 8'h42: a = "K"; 8'h4B: a = "L";
      8'h3A: a = "M"; 8'h31: a = "N"; 8'h44: a = "O"; 8'h4D: a = "P";
      8'h15: a = "Q"; 8'h2D: a = "R"; 8'h1B: a = "S"; 8'h2C: a = "T";
      8'h3C: a = "U"; 8'h2A: a = "V"; 8'h1D: a = "W"; 8'h22: a = "X";
      8'h35: a = "Y"; 8'h1A: a = "Z";
      8'h45: a = "0"; 8'h16: a = "1"; 8'h1E: a = "2"; 8'h26: a = "3";
      8'h25: a = "4"; 8'h2E: a = "5"; 8'h36: a = "6"; 8'h3D: a = "7";
      8'h3E: a = "8"; 8'h46: a = "9";
      8'h29: a = 8'h20;
      8'h5A: a = 8'h0D;
      default: a = 8'h3F;
    endcase
    return a;
  endfunction
`endif

  // Two-flop synchronisers plus one delay flop on the clock for edge detect.
  // Reset to 1 so an idle-high bus never looks like a falling edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      clk_m  <= 1'b1;
      clk_s  <= 1'b1;
      clk_d  <= 1'b1;
      data_m <= 1'b1;
      data_s <= 1'b1;
    end else begin
      clk_m  <= ps2_clk;
      clk_s  <= clk_m;
      clk_d  <= clk_s;
      data_m <= ps2_data;
      data_s <= data_m;
    end
  end

  assign fall = clk_d & ~clk_s;

  // Frame is shifted in from the top: after 11 falls frame[0] is the start
  // bit, frame[8:1] the byte, frame[9] parity and frame[10] the stop bit.
  assign rx_byte  = frame[8:1];
  assign frame_ok = ~frame[0] & frame[10] & (^frame[9:1]);
  // A fall wins over an expiring timeout in the same cycle.
  assign timeout  = (state == RECV) && !fall && (to_cnt == TO_LAST);

`ifdef PS2_ASCII_EN
  assign key_val = to_ascii(rx_byte);
`else
  assign key_val = rx_byte;
`endif

  always_comb begin
    deliver = 1'b0;
    if (state == CHECK && frame_ok && rx_byte != 8'hF0 && rx_byte != 8'hE0
        && !brk_flag) begin
`ifdef PS2_ASCII_EN
      deliver = !ext_flag;
`else
      deliver = 1'b1;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:  if (fall && !data_s) state_nx = RECV;
      RECV: begin
        if (fall && bit_cnt == 4'd10) state_nx = CHECK;
        else if (timeout)             state_nx = IDLE;
      end
      CHECK: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bit_cnt    <= 4'd0;
      frame      <= 11'h7FF;
      to_cnt     <= 16'd0;
      brk_flag   <= 1'b0;
      ext_flag   <= 1'b0;
      pulse_cnt  <= 4'd0;
      key_data   <= 8'h00;
      key_ext    <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      parity_err <= 1'b0;

      if (deliver)                pulse_cnt <= PULSE_LD;
      else if (pulse_cnt != 4'd0) pulse_cnt <= pulse_cnt - 4'd1;

      case (state)
        IDLE: begin
          to_cnt <= 16'd0;
          if (fall && !data_s) begin
            frame   <= {data_s, frame[10:1]};
            bit_cnt <= 4'd1;
          end
        end
        RECV: begin
          if (fall) begin
            frame   <= {data_s, frame[10:1]};
            bit_cnt <= bit_cnt + 4'd1;
            to_cnt  <= 16'd0;
          end else if (timeout) begin
            bit_cnt  <= 4'd0;
            to_cnt   <= 16'd0;
            brk_flag <= 1'b0;
            ext_flag <= 1'b0;
          end else begin
            to_cnt <= to_cnt + 16'd1;
          end
        end
        CHECK: begin
          bit_cnt <= 4'd0;
          if (!frame_ok) begin
            parity_err <= 1'b1;
            brk_flag   <= 1'b0;
            ext_flag   <= 1'b0;
          end else if (rx_byte == 8'hF0) begin
            brk_flag <= 1'b1;
          end else if (rx_byte == 8'hE0) begin
            ext_flag <= 1'b1;
          end else begin
            // Make code or release code: either way the prefix sequence ends.
            if (deliver) begin
              key_data <= key_val;
              key_ext  <= ext_flag;
            end
            brk_flag <= 1'b0;
            ext_flag <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign key_int = (pulse_cnt != 4'd0);

endmodule
